// File: rtl/lock_code_sender.sv
// Serial unlock-code transmitter: shifts a code into the lock detector,
// watches its unlock flag for a response window and retries on failure.
module lock_code_sender #(
  parameter int   CODE_W     = 8,
  parameter int   RESP_WIN   = 4,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:CODE_W] code,
  input  logic [2:0]      n_try,
  input  logic            unlock_in,
  output logic            x_out,
  output logic            busy,
  output logic            done,
  output logic            unlocked,
  output logic [2:0]      tries_used
);

  localparam int IW = $clog2(CODE_W + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(CODE_W);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [3:0]    WIN_LAST = 4'(RESP_WIN - 1);
  localparam logic [GW-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   idx_inc;
  logic [3:0]      win_q, win_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:CODE_W] code_q, code_d;
  logic [2:0]      att_q, att_d;
  logic [2:0]      used_q, used_d;
  logic            x_q, x_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            unl_q, unl_d;

  assign idx_inc = idx_q + IDX_ONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      win_q   <= '0;
      gap_q   <= '0;
      code_q  <= '0;
      att_q   <= '0;
      used_q  <= '0;
      x_q     <= IDLE_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      unl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      gap_q   <= gap_d;
      code_q  <= code_d;
      att_q   <= att_d;
      used_q  <= used_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      unl_q   <= unl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    gap_d   = gap_q;
    code_d  = code_q;
    att_d   = att_q;
    used_d  = used_q;
    x_d     = IDLE_BIT;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unl_d   = unl_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d  = code;
          att_d   = (n_try == 3'd0) ? 3'd1 : n_try;
          unl_d   = 1'b0;
          used_d  = 3'd1;
          busy_d  = 1'b1;
          x_d     = code[1];
          idx_d   = IDX_ONE;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (idx_q == IDX_LAST) begin
          win_d   = '0;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_inc;
          x_d   = code_q[idx_inc];
        end
      end
      S_WAIT: begin
        if (unlock_in) begin
          unl_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (win_q == WIN_LAST) begin
          if (used_q == att_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            used_d = used_q + 3'd1;
            // zero gap: next burst starts on the expiry edge itself
            if (GAP_CYCLES == 0) begin
              x_d     = code_q[1];
              idx_d   = IDX_ONE;
              state_d = S_SEND;
            end else begin
              gap_d   = '0;
              state_d = S_GAP;
            end
          end
        end else begin
          win_d = win_q + 4'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          x_d     = code_q[1];
          idx_d   = IDX_ONE;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_out      = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign unlocked   = unl_q;
  assign tries_used = used_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: timeline model of bursts, windows and gaps
// compared cycle by cycle against the design.
module tb_lock_code_sender;

  localparam int   CW = 8;
  localparam int   RW = 4;
  localparam int   GC = 2;
  localparam int   P  = CW + RW + GC;
  localparam logic IB = 1'b0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:CW]   code = '0;
  logic [2:0]    n_try = '0;
  logic          unlock_in = 1'b0;
  logic          x_out;
  logic          busy;
  logic          done;
  logic          unlocked;
  logic [2:0]    tries_used;

  int checks = 0;
  int errors = 0;
  int plan[7];

  always #5 clock = ~clock;

  lock_code_sender #(
    .CODE_W(CW),
    .RESP_WIN(RW),
    .GAP_CYCLES(GC),
    .IDLE_BIT(IB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .code(code),
    .n_try(n_try),
    .unlock_in(unlock_in),
    .x_out(x_out),
    .busy(busy),
    .done(done),
    .unlocked(unlocked),
    .tries_used(tries_used)
  );

  function automatic void clear_plan();
    for (int i = 0; i < 7; i++) plan[i] = 0;
  endfunction

  // plan[a] = window sample (1..RW) where unlock_in is high in attempt a,
  // 0 = no response in that attempt
  task automatic run_op(input string name, input logic [1:CW] c,
                        input logic [2:0] nt, input int noise,
                        input bit repulse);
    int   att, end_k, tf, o, w, te;
    bit   succ;
    logic ul, xe;
    att   = (nt == 3'd0) ? 1 : int'(nt);
    end_k = -1;
    succ  = 1'b0;
    tf    = att;
    for (int i = 0; i < att; i++) begin
      if (end_k < 0 && plan[i] != 0) begin
        end_k = i * P + CW + plan[i];
        succ  = 1'b1;
        tf    = i + 1;
      end
    end
    if (end_k < 0) end_k = (att - 1) * P + CW + RW;
    for (int k = 0; k <= end_k + 2; k++) begin
      start = (k == 0) || (repulse && k == 3);
      code  = (k == 0) ? c : CW'($urandom);
      n_try = (k == 0) ? nt : 3'($urandom);
      ul = (noise == 2) ? 1'b1 :
           (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int i = 0; i < att; i++) begin
        w = k - (i * P + CW);
        if (w >= 1 && w <= RW && k <= end_k) ul = (plan[i] == w);
      end
      unlock_in = ul;
      @(posedge clock);
      #1;
      if (k < end_k) begin
        o  = k % P;
        xe = (o < CW) ? c[o + 1] : IB;
      end else begin
        xe = IB;
      end
      te = 1;
      for (int i = 0; i < tf - 1; i++)
        if (i * P + CW + RW <= k) te++;
      checks++;
      if (x_out !== xe) begin
        errors++;
        $display("FAIL %s x_out k=%0d got %b want %b", name, k, x_out, xe);
      end
      checks++;
      if (busy !== (k < end_k)) begin
        errors++;
        $display("FAIL %s busy k=%0d got %b want %b", name, k, busy,
                 (k < end_k));
      end
      checks++;
      if (done !== (k == end_k)) begin
        errors++;
        $display("FAIL %s done k=%0d got %b want %b", name, k, done,
                 (k == end_k));
      end
      checks++;
      if (unlocked !== (succ && k >= end_k)) begin
        errors++;
        $display("FAIL %s unlocked k=%0d got %b want %b", name, k,
                 unlocked, (succ && k >= end_k));
      end
      checks++;
      if (tries_used !== 3'(te)) begin
        errors++;
        $display("FAIL %s tries_used k=%0d got %0d want %0d", name, k,
                 tries_used, te);
      end
    end
    start     = 1'b0;
    unlock_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (x_out !== IB) begin
      errors++;
      $display("FAIL reset_x got %b want %b", x_out, IB);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done got %b%b want 00", busy, done);
    end
    checks++;
    if (unlocked !== 1'b0 || tries_used !== 3'd0) begin
      errors++;
      $display("FAIL reset_result got %b/%0d want 0/0", unlocked,
               tries_used);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || x_out !== IB) begin
      errors++;
      $display("FAIL idle_hold got busy=%b x=%b want 0/%b", busy, x_out, IB);
    end
  endtask

  task automatic test_single_pass();
    clear_plan();
    plan[0] = 2;
    run_op("single_pass", 8'b1011_0010, 3'd1, 0, 1'b0);
  endtask

  task automatic test_three_fail();
    clear_plan();
    run_op("three_fail", 8'b1011_0010, 3'd3, 0, 1'b0);
  endtask

  task automatic test_second_window();
    clear_plan();
    plan[1] = 3;
    run_op("second_window", 8'b0110_1101, 3'd3, 0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    clear_plan();
    run_op("ignore_busy", 8'b1110_0101, 3'd1, 2, 1'b1);
  endtask

  task automatic test_zero_try();
    clear_plan();
    run_op("zero_try", 8'b1001_0110, 3'd0, 1, 1'b0);
  endtask

  task automatic test_reset_abort();
    clear_plan();
    start = 1'b1;
    code  = 8'b1100_1010;
    n_try = 3'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (x_out !== IB || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got x=%b busy=%b done=%b want %b/0/0",
               x_out, busy, done, IB);
    end
    checks++;
    if (unlocked !== 1'b0 || tries_used !== 3'd0) begin
      errors++;
      $display("FAIL abort_result got %b/%0d want 0/0", unlocked,
               tries_used);
    end
    code  = 8'b1000_0001;
    n_try = 3'd1;
    start = 1'b1;
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone got done=%b busy=%b want 0/0", done, busy);
    end
    reset = 1'b1;
    run_op("after_reset", 8'b1000_0001, 3'd1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:CW] c;
    logic [2:0]  nt;
    for (int n = 0; n < 25; n++) begin
      clear_plan();
      for (int i = 0; i < 7; i++)
        if ($urandom_range(0, 2) == 0) plan[i] = $urandom_range(1, RW);
      c  = CW'($urandom);
      nt = 3'($urandom);
      run_op("random", c, nt, int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_three_fail();
    test_second_window();
    test_ignore_busy();
    test_zero_try();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
